nonce_result_serializer: RTL and testbench

- Downstream of the nonce decoder: consumes its per-block result (valid/success/nonce).
- Buffers results in a small FIFO.
- Serialises each result as a byte-wide frame to the host link using a valid/ready handshake.
- Decouples the miner core from link back-pressure and flags lost results.

---
 rtl/nonce_result_pkg.sv | 23 ++
 rtl/nonce_result_serializer_if.sv | 21 ++
 rtl/nonce_result_fifo.sv | 53 +++++
 rtl/nonce_result_serializer.sv | 126 ++++++++++++
 tb/tb_nonce_result_serializer.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nonce_result_pkg.sv
// Shared types and constants for the nonce result serializer slice.
package nonce_result_pkg;

  typedef struct packed {
    logic        success;
    logic [31:0] nonce;
  } nonce_result_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STATUS = 2'd1,
    NONCE  = 2'd2
  } state_e;

  localparam logic [7:0] STATUS_OK_DEFAULT   = 8'hA5;
  localparam logic [7:0] STATUS_FAIL_DEFAULT = 8'h5A;

  // Nonce bytes go out little-endian: idx 0 is nonce[7:0].
  function automatic logic [7:0] nonce_byte(input logic [31:0] nonce, input logic [1:0] idx);
    return nonce[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/nonce_result_serializer_if.sv
// Result input and byte-link output bundle of the nonce result serializer.
interface nonce_result_serializer_if;
  logic        valid_i;
  logic        success_i;
  logic [31:0] nonce_i;
  logic [7:0]  byte_o;
  logic        byte_valid_o;
  logic        byte_ready_i;
  logic        busy_o;
  logic        overflow_o;

  modport slave (
    input  valid_i, success_i, nonce_i, byte_ready_i,
    output byte_o, byte_valid_o, busy_o, overflow_o
  );

  modport master (
    output valid_i, success_i, nonce_i, byte_ready_i,
    input  byte_o, byte_valid_o, busy_o, overflow_o
  );
endinterface

// File: rtl/nonce_result_fifo.sv
// Synchronous FIFO of decoded nonce results; caller qualifies push/pop.
module nonce_result_fifo
  import nonce_result_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  nonce_result_t wdata_i,
  output nonce_result_t rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  nonce_result_t mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(push_i) - CW'(pop_i);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      // On a full push+pop wr_ptr equals rd_ptr; the head is read before this write lands.
      if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/nonce_result_serializer.sv
// Buffers nonce decoder results and streams each one as a status(+nonce) byte frame.
module nonce_result_serializer
  import nonce_result_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter logic [7:0]  STATUS_OK   = STATUS_OK_DEFAULT,
  parameter logic [7:0]  STATUS_FAIL = STATUS_FAIL_DEFAULT
) (
  input logic                      clk,
  input logic                      rst,
  nonce_result_serializer_if.slave bus
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  state_e        state_q, state_d;
  nonce_result_t frame_q, frame_d;
  nonce_result_t head, wdata;
  logic [1:0]    idx_q, idx_d;
  logic [7:0]    byte_q, byte_d;
  logic          byte_valid_q, byte_valid_d;
  logic          busy_q, busy_d;
  logic          overflow_q, overflow_d;
  logic          push, pop, full, empty, xfer;
  logic [CW-1:0] count, count_next;

  assign wdata = {bus.success_i, bus.nonce_i};
  // A full FIFO still accepts a result when the FSM pops on the same edge.
  assign push  = bus.valid_i & (~full | pop);

  nonce_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wdata),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    idx_d   = idx_q;
    pop     = 1'b0;
    xfer    = byte_valid_q & bus.byte_ready_i;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          frame_d = head;
          state_d = STATUS;
        end
      end
      STATUS: begin
        if (xfer) begin
          if (frame_q.success) begin
            state_d = NONCE;
            idx_d   = '0;
          end else if (!empty) begin
            pop     = 1'b1;
            frame_d = head;
          end else begin
            state_d = IDLE;
          end
        end
      end
      NONCE: begin
        if (xfer) begin
          if (idx_q != 2'd3) begin
            idx_d = idx_q + 2'd1;
          end else if (!empty) begin
            pop     = 1'b1;
            frame_d = head;
            state_d = STATUS;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they line up with the state they describe.
  always_comb begin
    byte_valid_d = (state_d != IDLE);
    byte_d       = '0;
    case (state_d)
      STATUS:  byte_d = frame_d.success ? STATUS_OK : STATUS_FAIL;
      NONCE:   byte_d = nonce_byte(frame_d.nonce, idx_d);
      default: byte_d = '0;
    endcase
    count_next = count + CW'(push) - CW'(pop);
    busy_d     = (state_d != IDLE) | (count_next != '0);
    overflow_d = overflow_q | (bus.valid_i & full & ~pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      frame_q      <= '0;
      idx_q        <= '0;
      byte_q       <= '0;
      byte_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_q      <= frame_d;
      idx_q        <= idx_d;
      byte_q       <= byte_d;
      byte_valid_q <= byte_valid_d;
      busy_q       <= busy_d;
      overflow_q   <= overflow_d;
    end
  end

  assign bus.byte_o       = byte_q;
  assign bus.byte_valid_o = byte_valid_q;
  assign bus.busy_o       = busy_q;
  assign bus.overflow_o   = overflow_q;

endmodule

// File: tb/tb_nonce_result_serializer.sv
// Self-checking bench: frame table, hand-written corner sequences, randomized stream vs byte-queue model.
module tb_nonce_result_serializer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  nonce_result_serializer_if bus ();

  nonce_result_serializer #(.FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        success;
    logic [31:0] nonce;
    int          nbytes;
    logic [7:0]  bytes [5];
  } vec_t;

  vec_t       vecs [5];
  logic [7:0] stream_q [$];
  logic [7:0] rand_q [$];
  int         flen_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int i, input logic s, input logic [31:0] n, input int len,
                         input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input logic [7:0] b3, input logic [7:0] b4);
    vecs[i].success  = s;
    vecs[i].nonce    = n;
    vecs[i].nbytes   = len;
    vecs[i].bytes[0] = b0;
    vecs[i].bytes[1] = b1;
    vecs[i].bytes[2] = b2;
    vecs[i].bytes[3] = b3;
    vecs[i].bytes[4] = b4;
  endtask

  // Expected frame built from the frame-format rules.
  task automatic add_frame(input logic s, input logic [31:0] n);
    if (s) begin
      stream_q.push_back(8'hA5);
      for (int k = 0; k < 4; k++) stream_q.push_back(n[8*k +: 8]);
    end else begin
      stream_q.push_back(8'h5A);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic [31:0] n);
    bus.valid_i   = v;
    bus.success_i = s;
    bus.nonce_i   = n;
  endtask

  task automatic do_reset();
    #1;
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0);
    bus.byte_ready_i = 1'b0;
    step();
    step();
    check("reset byte_o", {24'h0, bus.byte_o}, 32'h0);
    check("reset byte_valid_o", {31'h0, bus.byte_valid_o}, 32'h0);
    check("reset busy_o", {31'h0, bus.busy_o}, 32'h0);
    check("reset overflow_o", {31'h0, bus.overflow_o}, 32'h0);
    rst = 1'b1;
    step();
  endtask

  // Consumes stream_q byte by byte; optional stall before byte stall_at and injected result at byte inj_at.
  task automatic expect_stream(input string name, input int stall_at, input int stall_len,
                               input int inj_at, input logic inj_s, input logic [31:0] inj_n);
    int idx = 0;
    int stalled = 0;
    int budget = 0;
    while (idx < stream_q.size() && budget < 500) begin
      budget++;
      drive(1'b0, 1'b0, 32'h0);
      if (idx == stall_at && stalled < stall_len) begin
        bus.byte_ready_i = 1'b0;
        stalled++;
      end else begin
        bus.byte_ready_i = 1'b1;
      end
      check({name, " valid"}, {31'h0, bus.byte_valid_o}, 32'h1);
      check({name, " byte"}, {24'h0, bus.byte_o}, {24'h0, stream_q[idx]});
      if (bus.byte_ready_i) begin
        if (idx == inj_at) drive(1'b1, inj_s, inj_n);
        idx++;
      end
      step();
    end
    drive(1'b0, 1'b0, 32'h0);
    check({name, " within budget"}, budget, (budget < 500) ? budget : 0);
    stream_q.delete();
  endtask

  initial begin
    logic        s;
    logic [31:0] n;
    int          budget;

    drive(1'b0, 1'b0, 32'h0);
    bus.byte_ready_i = 1'b0;

    set_vec(0, 1'b1, 32'hDEADBEEF, 5, 8'hA5, 8'hEF, 8'hBE, 8'hAD, 8'hDE);
    set_vec(1, 1'b0, 32'h12345678, 1, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00);
    set_vec(2, 1'b1, 32'h00000000, 5, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00);
    set_vec(3, 1'b1, 32'hFFFFFFFF, 5, 8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    set_vec(4, 1'b1, 32'h01020304, 5, 8'hA5, 8'h04, 8'h03, 8'h02, 8'h01);

    do_reset();

    // Table: single result from idle, ready held high.
    for (int v = 0; v < 5; v++) begin
      bus.byte_ready_i = 1'b1;
      check("idle busy before push", {31'h0, bus.busy_o}, 32'h0);
      drive(1'b1, vecs[v].success, vecs[v].nonce);
      step();
      drive(1'b0, 1'b0, 32'h0);
      check("latency no early valid", {31'h0, bus.byte_valid_o}, 32'h0);
      check("busy after push", {31'h0, bus.busy_o}, 32'h1);
      step();
      for (int b = 0; b < vecs[v].nbytes; b++) begin
        check("table valid", {31'h0, bus.byte_valid_o}, 32'h1);
        check("table byte", {24'h0, bus.byte_o}, {24'h0, vecs[v].bytes[b]});
        step();
      end
      check("table valid after frame", {31'h0, bus.byte_valid_o}, 32'h0);
      check("table busy after frame", {31'h0, bus.busy_o}, 32'h0);
    end

    // Back-pressure mid-nonce.
    bus.byte_ready_i = 1'b1;
    drive(1'b1, 1'b1, 32'hCAFEF00D);
    step();
    drive(1'b0, 1'b0, 32'h0);
    step();
    add_frame(1'b1, 32'hCAFEF00D);
    expect_stream("stall", 2, 3, -1, 1'b0, 32'h0);
    check("stall idle after", {31'h0, bus.byte_valid_o}, 32'h0);

    // Overflow: one frame stalled in flight, five more results, the last one dropped.
    do_reset();
    drive(1'b1, 1'b1, 32'hA0A1A2A3);
    step();
    drive(1'b0, 1'b0, 32'h0);
    step();
    add_frame(1'b1, 32'hA0A1A2A3);
    for (int i = 1; i <= 5; i++) begin
      s = (i != 2);
      n = 32'h1000_0000 * i + 32'h0055_AA00 + i;
      drive(1'b1, s, n);
      if (i < 5) add_frame(s, n);
      step();
      check("overflow flag", {31'h0, bus.overflow_o}, (i == 5) ? 32'h1 : 32'h0);
    end
    drive(1'b0, 1'b0, 32'h0);
    expect_stream("overflow drain", -1, 0, -1, 1'b0, 32'h0);
    check("overflow no extra frame", {31'h0, bus.byte_valid_o}, 32'h0);
    check("overflow sticky", {31'h0, bus.overflow_o}, 32'h1);
    check("overflow busy low", {31'h0, bus.busy_o}, 32'h0);

    // Full FIFO: push on the same edge the last nonce byte is accepted.
    do_reset();
    drive(1'b1, 1'b1, 32'h87654321);
    step();
    drive(1'b0, 1'b0, 32'h0);
    step();
    add_frame(1'b1, 32'h87654321);
    for (int i = 1; i <= 4; i++) begin
      s = (i != 3);
      n = 32'h0BAD_0000 + i;
      drive(1'b1, s, n);
      add_frame(s, n);
      step();
    end
    drive(1'b0, 1'b0, 32'h0);
    check("full no overflow yet", {31'h0, bus.overflow_o}, 32'h0);
    add_frame(1'b1, 32'hFEEDFACE);
    expect_stream("full push+pop", -1, 0, 4, 1'b1, 32'hFEEDFACE);
    check("full push+pop overflow", {31'h0, bus.overflow_o}, 32'h0);
    check("full push+pop busy", {31'h0, bus.busy_o}, 32'h0);

    // Reset mid-frame at nonce idx 1.
    do_reset();
    bus.byte_ready_i = 1'b1;
    drive(1'b1, 1'b1, 32'h11223344);
    step();
    drive(1'b0, 1'b0, 32'h0);
    step();
    check("pre-reset status", {24'h0, bus.byte_o}, 32'hA5);
    step();
    check("pre-reset idx0", {24'h0, bus.byte_o}, 32'h44);
    step();
    check("pre-reset idx1", {24'h0, bus.byte_o}, 32'h33);
    #1;
    rst = 1'b0;
    #1;
    check("async reset byte_o", {24'h0, bus.byte_o}, 32'h0);
    check("async reset valid", {31'h0, bus.byte_valid_o}, 32'h0);
    check("async reset busy", {31'h0, bus.busy_o}, 32'h0);
    step();
    rst = 1'b1;
    step();
    step();
    check("post-reset quiet", {31'h0, bus.byte_valid_o}, 32'h0);
    drive(1'b1, 1'b1, 32'h55667788);
    step();
    drive(1'b0, 1'b0, 32'h0);
    step();
    add_frame(1'b1, 32'h55667788);
    expect_stream("post-reset frame", -1, 0, -1, 1'b0, 32'h0);
    check("post-reset idle", {31'h0, bus.byte_valid_o}, 32'h0);

    // Randomized traffic; pushes are throttled so the model never needs overflow timing.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      bus.byte_ready_i = ($urandom_range(3) != 0);
      drive(1'b0, 1'b0, 32'h0);
      s = 1'b0;
      n = 32'h0;
      if (flen_q.size() < 4 && $urandom_range(2) == 0) begin
        s = 1'($urandom_range(1));
        n = $urandom;
        drive(1'b1, s, n);
      end
      if (bus.byte_valid_o && bus.byte_ready_i) begin
        if (rand_q.size() == 0) begin
          check("rand spurious byte", {31'h0, bus.byte_valid_o}, 32'h0);
        end else begin
          check("rand byte", {24'h0, bus.byte_o}, {24'h0, rand_q.pop_front()});
          flen_q[0] = flen_q[0] - 1;
          if (flen_q[0] == 0) void'(flen_q.pop_front());
        end
      end
      if (bus.valid_i) begin
        stream_q.delete();
        add_frame(s, n);
        foreach (stream_q[k]) rand_q.push_back(stream_q[k]);
        stream_q.delete();
        flen_q.push_back(s ? 5 : 1);
      end
      step();
    end
    drive(1'b0, 1'b0, 32'h0);
    bus.byte_ready_i = 1'b1;
    budget = 0;
    while (rand_q.size() != 0 && budget < 100) begin
      budget++;
      if (bus.byte_valid_o) begin
        check("rand drain byte", {24'h0, bus.byte_o}, {24'h0, rand_q.pop_front()});
      end
      step();
    end
    check("rand drain remaining", rand_q.size(), 0);
    step();
    check("rand end valid", {31'h0, bus.byte_valid_o}, 32'h0);
    check("rand end busy", {31'h0, bus.busy_o}, 32'h0);
    check("rand end overflow", {31'h0, bus.overflow_o}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
